// File: rtl/boundary_strip_if.sv
// Output stream of boundary_strip: interior pixels plus their frame coordinates.
//   oData   interior pixel {R,G,B}
//   oValid  oData/oXCnt/oYCnt are meaningful
//   oReady  consumer takes the pixel this cycle
//   oXCnt   column of oData (0..width-1)
//   oYCnt   row of oData (0..height-1)
// Handshake: a transfer happens on a clock edge where oValid && oReady are both
// high. Once oValid rises, oData/oXCnt/oYCnt stay stable until that transfer.
// The master never waits for oReady before raising oValid.
interface boundary_strip_if;
  logic [23:0] oData;
  logic        oValid;
  logic        oReady;
  logic [31:0] oXCnt;
  logic [31:0] oYCnt;

  modport master (output oData, output oValid, output oXCnt, output oYCnt, input oReady);
  modport slave  (input oData, input oValid, input oXCnt, input oYCnt, output oReady);
endinterface

// File: rtl/boundary_strip.sv
// boundary_strip: removes the zero padding that the filter front end places
// around each frame. It forwards only the width x height interior pixels, in
// raster order. A small output FIFO absorbs consumer stalls, because the
// upstream stream cannot be stalled.
//   clk, reset  clock; synchronous active-high reset
//   newFrame    one-cycle pulse on the first padded pixel of a frame
//   iValid/iData  padded input stream. It has no ready, so a pixel is dropped
//                 when the FIFO is full.
//   out         interior pixel stream (boundary_strip_if master)
//   oDone       one-cycle pulse after the last interior pixel transfers
//   oOverflow   sticky: a kept pixel was dropped on a full FIFO
//   oFrameErr   sticky: newFrame arrived while a frame was still in flight
//   dbg_state   current FSM state
module boundary_strip #(
  parameter int unsigned width      = 320,
  parameter int unsigned height     = 240,
  parameter int unsigned kernelSize = 7,
  parameter int unsigned fifoDepth  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             newFrame,
  input  logic             iValid,
  input  logic [23:0]      iData,
  boundary_strip_if.master out,
  output logic             oDone,
  output logic             oOverflow,
  output logic             oFrameErr,
  output logic [1:0]       dbg_state
);
  localparam int unsigned BW = (kernelSize - 1) / 2;
  localparam int unsigned PW = width + kernelSize - 1;
  localparam int unsigned PH = height + kernelSize - 1;
  localparam int unsigned AW = $clog2(fifoDepth);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(fifoDepth);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   in_x_q, in_x_d, in_y_q, in_y_d;
  logic [31:0]   out_x_q, out_x_d, out_y_q, out_y_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [AW:0]   count_q, count_d;
  logic [23:0]   mem_q [fifoDepth];
  logic          out_cmp_q, out_cmp_d, done_q, done_d, ovf_q, ovf_d, ferr_q, ferr_d;

  logic          active, rd, accept, keep, full, wr_en, last_in, final_xfer;
  logic [31:0]   cur_x, cur_y;

  // Show-ahead FIFO: the head entry is presented directly. The output is zero
  // while the FIFO is empty.
  assign out.oValid = (count_q != '0);
  assign out.oData  = out.oValid ? mem_q[rd_ptr_q] : '0;
  assign out.oXCnt  = out_x_q;
  assign out.oYCnt  = out_y_q;
  assign oDone      = done_q;
  assign oOverflow  = ovf_q;
  assign oFrameErr  = ferr_q;
  assign dbg_state  = state_q;

  always_comb begin
    active = (state_q == S_STREAM) || (state_q == S_DRAIN);
    rd     = out.oValid && out.oReady;
    // On a newFrame cycle a coincident pixel is padded pixel (0,0).
    cur_x  = newFrame ? '0 : in_x_q;
    cur_y  = newFrame ? '0 : in_y_q;
    accept = iValid && (newFrame || (state_q == S_STREAM));
    keep   = accept && (cur_x >= BW) && (cur_x < BW + width) &&
             (cur_y >= BW) && (cur_y < BW + height);
    full   = (count_q == FULL_CNT);
    // A write on a full FIFO is legal when the head leaves in the same cycle.
    // newFrame empties the FIFO, so a write is always possible then.
    wr_en  = keep && (newFrame || !full || rd);
    wr_addr = newFrame ? '0 : wr_ptr_q;
    last_in = accept && (cur_x == PW - 1) && (cur_y == PH - 1);
    final_xfer = rd && active && !newFrame &&
                 (out_x_q == width - 1) && (out_y_q == height - 1);

    in_x_d = in_x_q;
    in_y_d = in_y_q;
    if (accept) begin
      if (cur_x == PW - 1) begin
        in_x_d = '0;
        in_y_d = (cur_y == PH - 1) ? '0 : cur_y + 32'd1;
      end else begin
        in_x_d = cur_x + 32'd1;
        in_y_d = cur_y;
      end
    end else if (newFrame) begin
      in_x_d = '0;
      in_y_d = '0;
    end

    if (newFrame) begin
      rd_ptr_d = '0;
      wr_ptr_d = AW'(wr_en);
      count_d  = (AW+1)'(wr_en);
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(rd);
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd);
    end

    out_x_d = out_x_q;
    out_y_d = out_y_q;
    if (newFrame) begin
      out_x_d = '0;
      out_y_d = '0;
    end else if (rd) begin
      if (out_x_q == width - 1) begin
        out_x_d = '0;
        out_y_d = (out_y_q == height - 1) ? '0 : out_y_q + 32'd1;
      end else begin
        out_x_d = out_x_q + 32'd1;
      end
    end

    // The last interior pixel can leave while padding rows are still arriving.
    // out_cmp remembers this so the end of input can return straight to IDLE.
    out_cmp_d = newFrame ? 1'b0 : (out_cmp_q || final_xfer);
    done_d    = final_xfer;
    ovf_d     = ovf_q || (keep && !wr_en);
    ferr_d    = ferr_q || (newFrame && active);

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (newFrame) state_d = S_STREAM;
      S_STREAM: begin
        if (newFrame) state_d = S_STREAM;
        else if (last_in) state_d = (out_cmp_q || final_xfer) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (newFrame) state_d = S_STREAM;
        else if (final_xfer) state_d = S_DONE;
      end
      default:  state_d = newFrame ? S_STREAM : S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      in_x_q    <= '0;
      in_y_q    <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_cmp_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_x_q    <= in_x_d;
      in_y_q    <= in_y_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_cmp_q <= out_cmp_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  end

  // Storage needs no reset. Unoccupied entries are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= iData;
  end
endmodule

// File: tb/tb_boundary_strip.sv
module tb_boundary_strip;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned HEIGHT = 3;
  localparam int unsigned KSIZE = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BW = (KSIZE - 1) / 2;
  localparam int unsigned PW = WIDTH + KSIZE - 1;
  localparam int unsigned PH = HEIGHT + KSIZE - 1;
  localparam int unsigned NPAD = PW * PH;
  localparam int unsigned NOUT = WIDTH * HEIGHT;
  localparam int EW = 56;  // {frame-local output index[31:0], data[23:0]}

  logic        clk, reset, newFrame, iValid;
  logic [23:0] iData;
  logic        oDone, oOverflow, oFrameErr;
  logic [1:0]  dbg_state;

  boundary_strip_if bus();

  boundary_strip #(.width(WIDTH), .height(HEIGHT), .kernelSize(KSIZE), .fifoDepth(DEPTH)) dut (
    .clk(clk), .reset(reset), .newFrame(newFrame), .iValid(iValid), .iData(iData),
    .out(bus), .oDone(oDone), .oOverflow(oOverflow), .oFrameErr(oFrameErr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  int n_xfer = 0;
  int n_done = 0;
  bit mon_on = 0;

  // Reference model of the frame (owned by the driver).
  bit started = 0;
  int occ = 0;
  int in_cnt = 0;
  int xfer_cnt = 0;
  int push_idx = 0;
  bit ovf_now = 0, ovf_next = 0, ferr_now = 0, ferr_next = 0;
  // Per-cycle events handed from driver to monitor.
  bit nf_now = 0, rst_now = 0, push_now = 0;
  logic [EW-1:0] push_item = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit frame_active();
    return started && !(in_cnt == NPAD && xfer_cnt == NOUT);
  endfunction

  function automatic bit pick_rdy(input int mode, input bit in_input);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return !in_input;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit nf, input bit iv, input logic [23:0] d, input bit rdy);
    bit rd, act, keep;
    int x, y;
    @(negedge clk); #1;
    reset = 1'b0; newFrame = nf; iValid = iv; iData = d; bus.oReady = rdy;
    ovf_now = ovf_next;
    ferr_now = ferr_next;
    rd = (occ > 0) && rdy;
    act = frame_active();
    push_now = 0; nf_now = nf; rst_now = 0;
    if (nf) begin
      if (act) ferr_next = 1;
      started = 1; in_cnt = 0; xfer_cnt = 0; push_idx = 0; occ = 0;
    end else if (rd) begin
      occ--; xfer_cnt++;
    end
    if (iv && started && in_cnt < int'(NPAD)) begin
      x = in_cnt % PW;
      y = in_cnt / PW;
      in_cnt++;
      keep = (x >= int'(BW)) && (x < int'(BW + WIDTH)) && (y >= int'(BW)) && (y < int'(BW + HEIGHT));
      if (keep) begin
        if (occ < int'(DEPTH)) begin
          occ++;
          push_now = 1;
          push_item = {32'(push_idx), d};
          push_idx++;
        end else begin
          ovf_next = 1;
        end
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    repeat (cycles) begin
      @(negedge clk); #1;
      reset = 1'b1; newFrame = 0; iValid = 0; bus.oReady = 0;
      ovf_now = ovf_next; ferr_now = ferr_next;
      ovf_next = 0; ferr_next = 0;
      started = 0; occ = 0; in_cnt = 0; xfer_cnt = 0; push_idx = 0;
      push_now = 0; nf_now = 0; rst_now = 1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, bus.oValid, 0);
    check({tag, "_data"}, bus.oData, 0);
    check({tag, "_xcnt"}, bus.oXCnt, 0);
    check({tag, "_ycnt"}, bus.oYCnt, 0);
    check({tag, "_done"}, oDone, 0);
    check({tag, "_ovf"}, oOverflow, 0);
    check({tag, "_ferr"}, oFrameErr, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // rmode: 0 ready always, 1 random ready, 2 ready low during input then high.
  // gap: idle cycles between input pixels. abort_at: stop after that many pixels.
  task automatic run_frame(input int rmode, input int gap, input int abort_at, input int drain_max);
    for (int p = 0; p < int'(NPAD); p++) begin
      if (abort_at > 0 && p == abort_at) return;
      if (p > 0)
        for (int g = 0; g < gap; g++) step(0, 0, 24'($urandom), pick_rdy(rmode, 1));
      step(p == 0, 1, 24'($urandom), pick_rdy(rmode, 1));
    end
    for (int c = 0; c < drain_max && frame_active(); c++)
      step(0, 1'($urandom_range(0, 1)), 24'($urandom), pick_rdy(rmode, 0));
    repeat (2) step(0, 0, 24'($urandom), pick_rdy(rmode, 0));
    check("state_after_frame", dbg_state, frame_active() ? 2 : 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit stall_prev;
    bit done_exp;
    logic [23:0] data_prev;
    logic [EW-1:0] f;
    int idx;
    stall_prev = 0; done_exp = 0; data_prev = '0;
    wait (mon_on);
    forever begin
      @(negedge clk); #2;
      check("done", oDone, done_exp);
      check("overflow", oOverflow, ovf_now);
      check("frame_err", oFrameErr, ferr_now);
      check("valid", bus.oValid, exp_q.size() != 0);
      if (oDone) n_done++;
      done_exp = 0;
      if (bus.oValid && exp_q.size() != 0) begin
        f = exp_q[0];
        idx = int'(f[55:24]);
        check("data", bus.oData, f[23:0]);
        check("xcnt", bus.oXCnt, idx % WIDTH);
        check("ycnt", bus.oYCnt, idx / WIDTH);
        if (stall_prev) check("hold", bus.oData, data_prev);
        if (bus.oReady) begin
          done_exp = (idx == int'(NOUT) - 1) && !nf_now && !rst_now;
          void'(exp_q.pop_front());
          n_xfer++;
        end
      end
      stall_prev = bus.oValid && !bus.oReady && !nf_now && !rst_now;
      data_prev = bus.oData;
      if (rst_now) begin
        exp_q.delete();
        done_exp = 0;
      end else begin
        if (nf_now) exp_q.delete();
        if (push_now) exp_q.push_back(push_item);
      end
      push_now = 0; nf_now = 0; rst_now = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int b_x, b_d;
    reset = 1'b1; newFrame = 0; iValid = 0; iData = '0; bus.oReady = 0;
    do_reset(3);
    mon_on = 1;
    step(0, 0, 0, 1);
    check_reset_vals("reset");

    // Pixels before any newFrame must be ignored.
    repeat (5) step(0, 1, 24'($urandom), 1);

    // Contiguous frame, consumer always ready.
    b_x = n_xfer; b_d = n_done;
    run_frame(0, 0, 0, 60);
    check("s1_xfers", n_xfer - b_x, 12);
    check("s1_done", n_done - b_d, 1);

    // Sparse input: one valid every 3 cycles.
    b_x = n_xfer; b_d = n_done;
    run_frame(0, 2, 0, 60);
    check("s5_xfers", n_xfer - b_x, 12);
    check("s5_done", n_done - b_d, 1);

    // Aborted frame after 15 padded pixels, then a complete frame.
    b_x = n_xfer; b_d = n_done;
    run_frame(0, 0, 15, 0);
    run_frame(0, 0, 0, 60);
    check("s4_xfers", n_xfer - b_x, 18);
    check("s4_done", n_done - b_d, 1);
    check("s4_ferr", oFrameErr, 1);

    // Consumer stalled for the whole input: only the first 4 kept pixels survive.
    b_x = n_xfer; b_d = n_done;
    run_frame(2, 0, 0, 20);
    check("s3_xfers", n_xfer - b_x, 4);
    check("s3_done", n_done - b_d, 0);
    check("s3_ovf", oOverflow, 1);

    // Randomised frames: random ready, gaps and occasional aborts.
    for (int i = 0; i < 10; i++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NPAD - 1)) : 0;
      run_frame(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), ab, 80);
    end

    // Reset in the middle of a frame.
    for (int p = 0; p < 12; p++) step(p == 0, 1, 24'($urandom), 1'($urandom_range(0, 1)));
    do_reset(1);
    step(0, 0, 0, 0);
    check_reset_vals("midreset");

    // Clean frame after reset.
    b_x = n_xfer; b_d = n_done;
    run_frame(0, 0, 0, 60);
    check("post_xfers", n_xfer - b_x, 12);
    check("post_done", n_done - b_d, 1);

    repeat (3) step(0, 0, 0, 1);
    @(negedge clk); #5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/boundary_strip.md
# boundary_strip

Receives the padded pixel stream that the processing front end builds around each frame (zero boundary rows and columns for a kernelSize x kernelSize filter) and strips that padding. It emits only the width x height interior pixels, in raster order, over a valid/ready interface to downstream consumers (frame writer, colour pipeline). A small output FIFO absorbs downstream stalls, because the upstream filter pipeline cannot be stalled.

## Interface
- width, 320, active pixels per row
- height, 240, active rows per frame
- kernelSize, 7, filter kernel size (odd); boundaryWidth = (kernelSize-1)/2
- fifoDepth, 16, output FIFO entries (power of 2, >= 4)
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- newFrame  input  1  one-cycle pulse marking the first padded pixel of a frame
- iValid  input  1  padded-stream pixel valid
- iData  input  24  padded pixel {R,G,B}
- oData  output  24  interior pixel {R,G,B}
- oValid  output  1  oData valid
- oReady  input  1  downstream accepts oData this cycle
- oXCnt  output  32  column of the current oData (0..width-1)
- oYCnt  output  32  row of the current oData (0..height-1)
- oDone  output  1  one-cycle pulse after the last interior pixel transfers
- oOverflow  output  1  sticky: a kept pixel was dropped because the FIFO was full
- oFrameErr  output  1  sticky: newFrame arrived before the previous frame completed

## Operation
- Derived geometry:
  - widthWithBoundary W = width + kernelSize - 1.
  - Padded rows H = height + kernelSize - 1.
  - Padded pixels per frame = W*H.
- Input counters inX (0..W-1) and inY (0..H-1) advance on each accepted iValid. inX wraps to 0 and increments inY.
- A pixel is kept when boundaryWidth <= inX < boundaryWidth+width and boundaryWidth <= inY < boundaryWidth+height. All other pixels are discarded.
- A kept pixel is written to the FIFO. If the FIFO is full and no read occurs in the same cycle, the pixel is dropped and oOverflow is set. A write and a read in the same cycle on a full FIFO is legal and does not overflow.
- State machine:
  - IDLE: iValid ignored. newFrame → STREAM.
  - STREAM: counting and stripping. Acceptance of padded pixel W*H-1 → DRAIN.
  - DRAIN: iValid ignored; the FIFO empties. Transfer of output pixel width*height-1 → DONE.
  - DONE: oDone=1 for exactly one cycle → IDLE.
- newFrame handling:
  - On a newFrame cycle, inX/inY are set so that a simultaneous iValid pixel is padded pixel (0,0).
  - newFrame in STREAM or DRAIN: counters, output counters and FIFO are cleared, oFrameErr is set, and the state goes to STREAM. No oDone is issued for the aborted frame.
  - newFrame in DONE: oDone still pulses, and the next state is STREAM.
- Output handshake:
  - A transfer occurs when oValid && oReady.
  - While oValid && !oReady, oData, oXCnt and oYCnt hold stable.
  - oXCnt/oYCnt advance on each transfer. oXCnt wraps at width and increments oYCnt.
- reset: all state is cleared, including the sticky flags.

## Timing
- Reset values:
  - oData=0, oValid=0, oXCnt=0, oYCnt=0, oDone=0, oOverflow=0, oFrameErr=0.
  - inX=inY=0, FIFO empty, state IDLE.
- Latency: a kept pixel accepted at cycle N with the FIFO empty drives oValid=1 with that data at cycle N+1 (registered output, show-ahead FIFO).
- Sustained rate is one pixel per cycle in and out while oReady=1. With oReady=1 permanently the FIFO never holds more than 1 entry.
- oDone asserts the cycle after the final transfer, then deasserts.
- oOverflow and oFrameErr assert the cycle after the offending event and stay high until reset.

## Test plan
Parameters for scenarios 1-5: width=4, height=3, kernelSize=3, giving W=6, H=5, 30 padded pixels and 12 kept.

1. newFrame, then 30 consecutive iValid with iData = padded index, oReady=1 → exactly the 12 indices 7,8,9,10,13,14,15,16,19,20,21,22 are output. oXCnt/oYCnt step 0..3/0..2. oDone pulses once, one cycle after the 12th transfer.
2. Same stimulus with oReady toggled pseudo-randomly at 50% (fifoDepth=16) → same 12 values in order. Data holds while stalled. oOverflow=0.
3. fifoDepth=4 with oReady=0 throughout the input → first 4 kept pixels (7,8,9,10) retained. oOverflow=1 from the cycle after pixel 13 is dropped. After oReady=1, exactly 4 pixels are output and no oDone occurs.
4. newFrame issued after 15 padded pixels, followed by a full 30-pixel frame → oFrameErr=1. Output contains only the second frame's 12 pixels, starting at oXCnt=0/oYCnt=0. One oDone.
5. iValid gaps (1 valid every 3 cycles) → identical output to scenario 1. Each kept pixel appears one cycle after its input.
6. Default parameters (width=320, height=240, kernelSize=7), 326*246=80196 pixels → 76800 transfers. Last oXCnt=319, oYCnt=239. Reset asserted mid-frame returns all outputs to reset values the next cycle.
